// File: rtl/pmem_line_responder.sv
// pmem_line_responder: line-addressed backing store that answers 128-bit cache
// line reads/writes with a single-cycle pmem_resp_o after LATENCY cycles.
//
// state | meaning
// ------+-------------------------------------------------------------------
// IDLE  | waiting for pmem_read_i / pmem_write_i; accepts and latches request
// BUSY  | counting down latency; aborts if the latched request line drops
// RESP  | pmem_resp_o high for this cycle; writes commit on the exit edge
module pmem_line_responder #(
    parameter int LATENCY = 4,
    parameter int LINES   = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  pmem_address_i,
    input  logic         pmem_read_i,
    input  logic         pmem_write_i,
    input  logic [127:0] pmem_wdata_i,
    output logic [127:0] pmem_rdata_o,
    output logic         pmem_resp_o,
    output logic         proto_err_o
);
    localparam int         IDXW     = $clog2(LINES);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic [3:0]      cnt_d;
    logic [IDXW-1:0] idx_q;
    logic [IDXW-1:0] idx_d;
    logic            is_wr_q;
    logic [127:0]    wdata_q;
    logic [127:0]    rdata_q;
    logic            resp_q;
    logic            perr_q;
    logic            req_held;
    logic [127:0]    mem_q [LINES];

    // Only the line-index bits of the address matter; offset and upper bits alias.
    logic unused_addr;
    assign unused_addr = ^pmem_address_i;

    // Next counter value, incoming line index and whether the accepted request is still asserted.
    always_comb begin
        cnt_d    = cnt_q - 4'd1;
        idx_d    = pmem_address_i[4 +: IDXW];
        req_held = is_wr_q ? pmem_write_i : pmem_read_i;
    end

    // Request FSM, latency counter, registered outputs and the line store.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            is_wr_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            resp_q  <= 1'b0;
            perr_q  <= 1'b0;
            for (int i = 0; i < LINES; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            resp_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pmem_read_i || pmem_write_i) begin
                        idx_q   <= idx_d;
                        is_wr_q <= pmem_write_i;
                        wdata_q <= pmem_wdata_i;
                        cnt_q   <= CNT_LOAD;
                        // Both lines high: the write wins, but the initiator is flagged.
                        if (pmem_read_i && pmem_write_i) begin
                            perr_q <= 1'b1;
                        end
                        if (CNT_LOAD == 4'd0) begin
                            state_q <= RESP;
                            resp_q  <= 1'b1;
                            if (!pmem_write_i) begin
                                rdata_q <= mem_q[idx_d];
                            end
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (pmem_read_i && pmem_write_i) begin
                        perr_q <= 1'b1;
                    end
                    if (!req_held) begin
                        // Initiator withdrew: nothing is committed or answered.
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_d == 4'd0) begin
                            state_q <= RESP;
                            resp_q  <= 1'b1;
                            if (!is_wr_q) begin
                                rdata_q <= mem_q[idx_q];
                            end
                        end
                    end
                end
                RESP: begin
                    // Commit here so a read accepted next cycle already sees the new line.
                    if (is_wr_q) begin
                        mem_q[idx_q] <= wdata_q;
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pmem_rdata_o = rdata_q;
    assign pmem_resp_o  = resp_q;
    assign proto_err_o  = perr_q;

endmodule

// File: tb/tb_pmem_line_responder.sv
// Bench for pmem_line_responder: two instances (LATENCY=4 and LATENCY=1),
// a transaction-level model of the store and response timing, and a
// per-cycle comparison of resp, rdata and proto_err against that model.
module tb_pmem_line_responder;

    logic         clk = 1'b0;
    logic         reset_i [2];
    logic [15:0]  addr_i  [2];
    logic         rd_i    [2];
    logic         wr_i    [2];
    logic [127:0] wdata_i [2];
    logic [127:0] rdata_o [2];
    logic         resp_o  [2];
    logic         perr_o  [2];

    always #5 clk = ~clk;

    pmem_line_responder #(.LATENCY(4), .LINES(64)) u_dut0 (
        .clk            (clk),
        .reset          (reset_i[0]),
        .pmem_address_i (addr_i[0]),
        .pmem_read_i    (rd_i[0]),
        .pmem_write_i   (wr_i[0]),
        .pmem_wdata_i   (wdata_i[0]),
        .pmem_rdata_o   (rdata_o[0]),
        .pmem_resp_o    (resp_o[0]),
        .proto_err_o    (perr_o[0])
    );

    pmem_line_responder #(.LATENCY(1), .LINES(64)) u_dut1 (
        .clk            (clk),
        .reset          (reset_i[1]),
        .pmem_address_i (addr_i[1]),
        .pmem_read_i    (rd_i[1]),
        .pmem_write_i   (wr_i[1]),
        .pmem_wdata_i   (wdata_i[1]),
        .pmem_rdata_o   (rdata_o[1]),
        .pmem_resp_o    (resp_o[1]),
        .proto_err_o    (perr_o[1])
    );

    // Model state, per instance.
    logic [127:0] mem_m     [2][64];
    logic [127:0] exp_rdata [2];
    bit           exp_perr  [2];
    int           resp_at   [2];
    bit           pend_rd   [2];
    logic [127:0] pend_data [2];
    bit           active    [2];
    int           obs_resp  [2];
    int           cyc;
    int           errors;
    int           checks;
    bit           checking;

    function automatic int lat(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic int idx_of(input logic [15:0] a);
        return int'(a[9:4]);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    // One clock: compare outputs mid-cycle, then advance the model over the edge.
    task automatic step();
        @(negedge clk);
        if (checking) begin
            for (int d = 0; d < 2; d++) begin
                bit er;
                er = (cyc == resp_at[d]);
                if (er && pend_rd[d]) exp_rdata[d] = pend_data[d];
                if (resp_o[d] === 1'b1) obs_resp[d] = cyc;
                check($sformatf("resp%0d", d), 128'(resp_o[d]), 128'(er));
                check($sformatf("rdata%0d", d), rdata_o[d], exp_rdata[d]);
                check($sformatf("perr%0d", d), 128'(perr_o[d]), 128'(exp_perr[d]));
            end
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (reset_i[d]) begin
                for (int i = 0; i < 64; i++) mem_m[d][i] = '0;
                exp_rdata[d] = '0;
                exp_perr[d]  = 1'b0;
                resp_at[d]   = -1;
            end else if (active[d] && rd_i[d] && wr_i[d]) begin
                exp_perr[d] = 1'b1;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic issue(input int d, input bit r, input bit w, input logic [15:0] a,
                         input logic [127:0] wd);
        rd_i[d]      = r;
        wr_i[d]      = w;
        addr_i[d]    = a;
        wdata_i[d]   = wd;
        active[d]    = 1'b1;
        resp_at[d]   = cyc + lat(d);
        pend_rd[d]   = !w;
        pend_data[d] = mem_m[d][idx_of(a)];
    endtask

    // Full request; abort_at>0 drops the request in that cycle, inject pulses the other line in cycle 1.
    task automatic req(input int d, input bit r, input bit w, input logic [15:0] a,
                       input logic [127:0] wd, input int abort_at, input bit inject,
                       output int start);
        start = cyc;
        issue(d, r, w, a, wd);
        for (int k = 1; k <= lat(d); k++) begin
            step();
            addr_i[d]  = 16'($urandom);
            wdata_i[d] = rand128();
            rd_i[d]    = r;
            wr_i[d]    = w;
            if (abort_at != 0 && k == abort_at) begin
                rd_i[d]    = 1'b0;
                wr_i[d]    = 1'b0;
                active[d]  = 1'b0;
                resp_at[d] = -1;
                step();
                return;
            end
            if (k == lat(d)) active[d] = 1'b0;
            else if (inject && k == 1) begin
                if (w) rd_i[d] = 1'b1;
                else   wr_i[d] = 1'b1;
            end
        end
        step();
        if (w) mem_m[d][idx_of(a)] = wd;
        rd_i[d] = 1'b0;
        wr_i[d] = 1'b0;
    endtask

    task automatic reset_pulse(input int d);
        reset_i[d] = 1'b1;
        rd_i[d]    = 1'b0;
        wr_i[d]    = 1'b0;
        active[d]  = 1'b0;
        step();
        reset_i[d] = 1'b0;
    endtask

    // Start a request, then reset in cycle 'at'; keep leaves the request line high through reset.
    task automatic reset_mid(input int d, input bit r, input bit w, input logic [15:0] a,
                             input logic [127:0] wd, input int at, input bit keep);
        issue(d, r, w, a, wd);
        for (int k = 1; k <= at; k++) step();
        reset_i[d] = 1'b1;
        active[d]  = 1'b0;
        if (!keep) begin
            rd_i[d] = 1'b0;
            wr_i[d] = 1'b0;
        end
        step();
        reset_i[d] = 1'b0;
    endtask

    initial begin
        int s;
        logic [127:0] db, va, vb, vc, vd;
        db = 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF;
        va = 128'hAAAA0000_11112222_33334444_5555AAAA;
        vb = 128'hBBBB9999_88887777_66665555_4444BBBB;
        vc = 128'hCCCC1234_56789ABC_DEF01234_5678CCCC;
        vd = 128'hDDDD0F0F_F0F00F0F_F0F00F0F_F0F0DDDD;
        errors = 0;
        checks = 0;
        cyc = 0;
        checking = 1'b0;
        for (int d = 0; d < 2; d++) begin
            reset_i[d] = 1'b1;
            rd_i[d] = 1'b0;
            wr_i[d] = 1'b0;
            addr_i[d] = '0;
            wdata_i[d] = '0;
            active[d] = 1'b0;
            resp_at[d] = -1;
            pend_rd[d] = 1'b0;
            pend_data[d] = '0;
            exp_rdata[d] = '0;
            exp_perr[d] = 1'b0;
            obs_resp[d] = -100;
        end
        step();
        step();
        reset_i[0] = 1'b0;
        reset_i[1] = 1'b0;
        checking = 1'b1;

        // Read of a fresh line after reset.
        req(0, 1, 0, 16'h0040, '0, 0, 0, s);
        check("t1_lat", 128'(obs_resp[0] - s), 128'd4);
        check("t1_rdata", rdata_o[0], 128'h0);

        // Write then immediate read of the same line at a different offset.
        req(0, 0, 1, 16'h0120, db, 0, 0, s);
        req(0, 1, 0, 16'h012C, '0, 0, 0, s);
        check("t2_lat", 128'(obs_resp[0] - s), 128'd4);
        check("t2_rdata", rdata_o[0], db);

        // Aliasing: 0x0410 maps onto the same line as 0x0010.
        req(0, 0, 1, 16'h0010, va, 0, 0, s);
        req(0, 0, 1, 16'h0410, vb, 0, 0, s);
        req(0, 1, 0, 16'h0010, '0, 0, 0, s);
        check("t3_alias", rdata_o[0], vb);

        // Aborted read and aborted write.
        obs_resp[0] = -100;
        req(0, 1, 0, 16'h0010, '0, 2, 0, s);
        check("t4_abort_noresp", 128'(obs_resp[0] < 0 ? 1 : 0), 128'd1);
        req(0, 1, 0, 16'h0010, '0, 0, 0, s);
        check("t4_after_abort_lat", 128'(obs_resp[0] - s), 128'd4);
        req(0, 0, 1, 16'h0010, rand128(), 2, 0, s);
        req(0, 1, 0, 16'h0010, '0, 0, 0, s);
        check("t4_wabort_store", rdata_o[0], vb);

        // Both request lines high: treated as a write, flag set and sticky.
        req(0, 1, 1, 16'h0200, vc, 0, 0, s);
        check("t5_lat", 128'(obs_resp[0] - s), 128'd4);
        check("t5_perr", 128'(perr_o[0]), 128'd1);
        step();
        step();
        req(0, 1, 0, 16'h0200, '0, 0, 0, s);
        check("t5_rdata", rdata_o[0], vc);
        check("t5_perr_sticky", 128'(perr_o[0]), 128'd1);

        // Both high during BUSY also flags.
        reset_pulse(0);
        check("t6_perr_cleared", 128'(perr_o[0]), 128'd0);
        req(0, 1, 0, 16'h0080, '0, 0, 1, s);
        check("t6_busy_perr", 128'(perr_o[0]), 128'd1);

        // Reset mid-write: no response, no commit, outputs cleared.
        reset_pulse(0);
        req(0, 0, 1, 16'h0040, va, 0, 0, s);
        req(0, 1, 0, 16'h0040, '0, 0, 0, s);
        check("t7_pre_rdata", rdata_o[0], va);
        req(0, 0, 1, 16'h0300, vd, 0, 0, s);
        obs_resp[0] = -100;
        reset_mid(0, 0, 1, 16'h0300, vd, 3, 0);
        step();
        check("t7_noresp", 128'(obs_resp[0] < 0 ? 1 : 0), 128'd1);
        check("t7_rdata_cleared", rdata_o[0], 128'h0);
        req(0, 1, 0, 16'h0300, '0, 0, 0, s);
        check("t7_store_cleared", rdata_o[0], 128'h0);

        // Request held through reset is accepted as new in the cycle after.
        req(0, 0, 1, 16'h0040, vb, 0, 0, s);
        reset_mid(0, 1, 0, 16'h0040, '0, 2, 1);
        req(0, 1, 0, 16'h0040, '0, 0, 0, s);
        check("t8_held_lat", 128'(obs_resp[0] - s), 128'd4);

        // Random traffic on the LATENCY=4 instance.
        reset_pulse(0);
        for (int n = 0; n < 40; n++) begin
            logic [15:0] a;
            bit w;
            int ab;
            a = 16'($urandom);
            a[9:4] = 6'($urandom_range(0, 7));
            w = 1'($urandom);
            ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
            req(0, !w, w, a, rand128(), ab, 0, s);
            repeat ($urandom_range(0, 2)) step();
        end

        // LATENCY=1 instance.
        reset_pulse(1);
        req(1, 1, 0, 16'h0040, '0, 0, 0, s);
        check("l1_lat", 128'(obs_resp[1] - s), 128'd1);
        req(1, 0, 1, 16'h0050, va, 0, 0, s);
        req(1, 1, 0, 16'h0050, '0, 0, 0, s);
        check("l1_lat2", 128'(obs_resp[1] - s), 128'd1);
        check("l1_rdata", rdata_o[1], va);
        for (int n = 0; n < 30; n++) begin
            logic [15:0] a;
            bit w;
            a = 16'($urandom);
            a[9:4] = 6'($urandom_range(0, 7));
            w = 1'($urandom);
            req(1, !w, w, a, rand128(), 0, 0, s);
            repeat ($urandom_range(0, 1)) step();
        end
        req(1, 1, 1, 16'h0200, vc, 0, 0, s);
        check("l1_perr", 128'(perr_o[1]), 128'd1);
        req(1, 1, 0, 16'h0200, '0, 0, 0, s);
        check("l1_both_rdata", rdata_o[1], vc);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
